// File: rtl/bp_be_reg_scoreboard_pkg.sv
// Shared types and constants for the BE register-hazard scoreboard.
package bp_be_reg_scoreboard_pkg;

    localparam int sb_reg_addr_width_gp = 5;
    localparam int sb_int_ports_gp      = 2;
    localparam int sb_fp_ports_gp       = 3;

    // Counter width needed to hold 0..max_pending writers.
    function automatic int sb_cnt_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    localparam int sb_cnt_width_gp = sb_cnt_width(3);

    // Source-read query as carried by the registered preissue packet.
    typedef struct packed {
        logic                            irs1_v;
        logic                            irs2_v;
        logic                            frs1_v;
        logic                            frs2_v;
        logic                            frs3_v;
        logic [sb_reg_addr_width_gp-1:0] rs1_addr;
        logic [sb_reg_addr_width_gp-1:0] rs2_addr;
        logic [sb_reg_addr_width_gp-1:0] rs3_addr;
    } bp_be_scoreboard_query_s;

endpackage

// File: rtl/bp_be_reg_scoreboard_if.sv
// Issue/writeback/query bundle between the dispatch checker and the scoreboard.
interface bp_be_reg_scoreboard_if
    import bp_be_reg_scoreboard_pkg::*;
#(
    parameter int reg_addr_width_p = sb_reg_addr_width_gp
);
    logic                        clr_v_i;
    logic                        issue_v_i;
    logic                        issue_irf_w_v_i;
    logic                        issue_frf_w_v_i;
    logic [reg_addr_width_p-1:0] issue_rd_addr_i;
    logic                        issue_ready_o;
    logic                        iwb_v_i;
    logic [reg_addr_width_p-1:0] iwb_addr_i;
    logic                        fwb_v_i;
    logic [reg_addr_width_p-1:0] fwb_addr_i;
    logic                        irs1_v_i;
    logic                        irs2_v_i;
    logic                        frs1_v_i;
    logic                        frs2_v_i;
    logic                        frs3_v_i;
    logic [reg_addr_width_p-1:0] rs1_addr_i;
    logic [reg_addr_width_p-1:0] rs2_addr_i;
    logic [reg_addr_width_p-1:0] rs3_addr_i;
    logic                        irs1_busy_o;
    logic                        irs2_busy_o;
    logic                        frs1_busy_o;
    logic                        frs2_busy_o;
    logic                        frs3_busy_o;
    logic                        stall_o;
    logic                        empty_o;
    logic                        underflow_o;

    modport master (
        output clr_v_i, issue_v_i, issue_irf_w_v_i, issue_frf_w_v_i, issue_rd_addr_i,
        output iwb_v_i, iwb_addr_i, fwb_v_i, fwb_addr_i,
        output irs1_v_i, irs2_v_i, frs1_v_i, frs2_v_i, frs3_v_i,
        output rs1_addr_i, rs2_addr_i, rs3_addr_i,
        input  issue_ready_o, irs1_busy_o, irs2_busy_o, frs1_busy_o, frs2_busy_o, frs3_busy_o,
        input  stall_o, empty_o, underflow_o
    );

    modport slave (
        input  clr_v_i, issue_v_i, issue_irf_w_v_i, issue_frf_w_v_i, issue_rd_addr_i,
        input  iwb_v_i, iwb_addr_i, fwb_v_i, fwb_addr_i,
        input  irs1_v_i, irs2_v_i, frs1_v_i, frs2_v_i, frs3_v_i,
        input  rs1_addr_i, rs2_addr_i, rs3_addr_i,
        output issue_ready_o, irs1_busy_o, irs2_busy_o, frs1_busy_o, frs2_busy_o, frs3_busy_o,
        output stall_o, empty_o, underflow_o
    );

endinterface

// File: rtl/bp_be_reg_scoreboard_bank.sv
// One register bank of pending-write counters with hazard read ports.
module bp_be_reg_scoreboard_bank
    import bp_be_reg_scoreboard_pkg::*;
#(
    parameter int els_p         = 32,
    parameter bit zero_reg_p    = 1'b0,
    parameter int max_pending_p = 3,
    parameter bit wb_bypass_p   = 1'b1,
    parameter int addr_width_p  = 5,
    parameter int ports_p       = 3
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                clr_v_i,
    input  logic                                inc_v_i,
    input  logic [addr_width_p-1:0]             rd_addr_i,
    input  logic                                wb_v_i,
    input  logic [addr_width_p-1:0]             wb_addr_i,
    input  logic [ports_p-1:0]                  rs_v_i,
    input  logic [ports_p-1:0][addr_width_p-1:0] rs_addr_i,
    output logic [ports_p-1:0]                  busy_o,
    output logic                                rd_full_o,
    output logic                                underflow_o,
    output logic                                empty_o
);

    localparam int                      cnt_width_lp = sb_cnt_width(max_pending_p);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp   = cnt_width_lp'(max_pending_p);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp   = cnt_width_lp'(1);

    logic [cnt_width_lp-1:0] count_view [els_p];
    logic [els_p-1:0]        nonzero;
    logic [els_p-1:0]        uf_hit;

    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_el
            // Register 0 of the integer bank is hardwired and never tracked.
            localparam bit tracked_lp = !(zero_reg_p && (gi == 0));

            logic                    inc;
            logic                    dec;
            logic [cnt_width_lp-1:0] cnt_reg;
            logic [cnt_width_lp-1:0] cnt_next;
            logic                    uf_next;

            assign inc = tracked_lp & inc_v_i & (rd_addr_i == addr_width_p'(gi));
            assign dec = tracked_lp & wb_v_i  & (wb_addr_i == addr_width_p'(gi));

            // Next count: flush wins, simultaneous issue+writeback cancel, decrement floors at 0.
            always_comb begin
                cnt_next = cnt_reg;
                uf_next  = 1'b0;
                if (clr_v_i) begin
                    cnt_next = '0;
                end else if (inc && !dec) begin
                    cnt_next = cnt_reg + cnt_one_lp;
                end else if (dec && !inc) begin
                    if (cnt_reg == '0) begin
                        uf_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - cnt_one_lp;
                    end
                end
            end

            // Counter state.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign count_view[gi] = cnt_reg;
            assign nonzero[gi]    = |cnt_reg;
            assign uf_hit[gi]     = uf_next;
        end

        for (gi = 0; gi < ports_p; gi++) begin : g_port
            logic [cnt_width_lp-1:0] cnt_rd;
            logic                    wb_clears;

            assign cnt_rd = count_view[rs_addr_i[gi]];
            // A writeback retiring the last pending writer releases the source this cycle.
            assign wb_clears = wb_bypass_p & wb_v_i & (wb_addr_i == rs_addr_i[gi])
                             & (cnt_rd == cnt_one_lp);
            assign busy_o[gi] = rs_v_i[gi] & (cnt_rd != '0) & ~wb_clears;
        end
    endgenerate

    assign rd_full_o   = (count_view[rd_addr_i] == cnt_max_lp);
    assign underflow_o = |uf_hit;
    assign empty_o     = ~|nonzero;

endmodule

// File: rtl/bp_be_reg_scoreboard.sv
// Register-hazard scoreboard: integer and FP pending-write tracking for dispatch.
module bp_be_reg_scoreboard
    import bp_be_reg_scoreboard_pkg::*;
#(
    parameter int max_pending_p    = 3,
    parameter bit wb_bypass_p      = 1'b1,
    parameter int reg_addr_width_p = sb_reg_addr_width_gp
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_be_reg_scoreboard_if.slave  sb_if
);

    bp_be_scoreboard_query_s    query;
    logic                       int_w;
    logic                       fp_w;
    logic                       int_full;
    logic                       fp_full;
    logic                       issue_ready;
    logic                       int_inc;
    logic                       fp_inc;
    logic [sb_int_ports_gp-1:0] int_busy;
    logic [sb_fp_ports_gp-1:0]  fp_busy;
    logic                       int_uf;
    logic                       fp_uf;
    logic                       int_empty;
    logic                       fp_empty;
    logic                       underflow_reg;

    // Pack the source-read flags into the shared query format.
    always_comb begin
        query          = '0;
        query.irs1_v   = sb_if.irs1_v_i;
        query.irs2_v   = sb_if.irs2_v_i;
        query.frs1_v   = sb_if.frs1_v_i;
        query.frs2_v   = sb_if.frs2_v_i;
        query.frs3_v   = sb_if.frs3_v_i;
        query.rs1_addr = sb_if.rs1_addr_i;
        query.rs2_addr = sb_if.rs2_addr_i;
        query.rs3_addr = sb_if.rs3_addr_i;
    end

    // The integer bank takes the write when both bank flags are (illegally) set.
    assign int_w = sb_if.issue_irf_w_v_i;
    assign fp_w  = sb_if.issue_frf_w_v_i & ~sb_if.issue_irf_w_v_i;

    // Readiness looks only at registered counts, never at same-cycle writebacks.
    assign issue_ready = ~((int_w & int_full) | (fp_w & fp_full));
    assign int_inc     = sb_if.issue_v_i & issue_ready & int_w;
    assign fp_inc      = sb_if.issue_v_i & issue_ready & fp_w;

    bp_be_reg_scoreboard_bank #(
        .els_p        (32),
        .zero_reg_p   (1'b1),
        .max_pending_p(max_pending_p),
        .wb_bypass_p  (wb_bypass_p),
        .addr_width_p (reg_addr_width_p),
        .ports_p      (sb_int_ports_gp)
    ) int_bank (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_v_i    (sb_if.clr_v_i),
        .inc_v_i    (int_inc),
        .rd_addr_i  (sb_if.issue_rd_addr_i),
        .wb_v_i     (sb_if.iwb_v_i),
        .wb_addr_i  (sb_if.iwb_addr_i),
        .rs_v_i     ({query.irs2_v, query.irs1_v}),
        .rs_addr_i  ({query.rs2_addr, query.rs1_addr}),
        .busy_o     (int_busy),
        .rd_full_o  (int_full),
        .underflow_o(int_uf),
        .empty_o    (int_empty)
    );

    bp_be_reg_scoreboard_bank #(
        .els_p        (32),
        .zero_reg_p   (1'b0),
        .max_pending_p(max_pending_p),
        .wb_bypass_p  (wb_bypass_p),
        .addr_width_p (reg_addr_width_p),
        .ports_p      (sb_fp_ports_gp)
    ) fp_bank (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_v_i    (sb_if.clr_v_i),
        .inc_v_i    (fp_inc),
        .rd_addr_i  (sb_if.issue_rd_addr_i),
        .wb_v_i     (sb_if.fwb_v_i),
        .wb_addr_i  (sb_if.fwb_addr_i),
        .rs_v_i     ({query.frs3_v, query.frs2_v, query.frs1_v}),
        .rs_addr_i  ({query.rs3_addr, query.rs2_addr, query.rs1_addr}),
        .busy_o     (fp_busy),
        .rd_full_o  (fp_full),
        .underflow_o(fp_uf),
        .empty_o    (fp_empty)
    );

    // Sticky underflow flag, cleared by reset or flush.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            underflow_reg <= 1'b0;
        end else if (sb_if.clr_v_i) begin
            underflow_reg <= 1'b0;
        end else begin
            underflow_reg <= underflow_reg | int_uf | fp_uf;
        end
    end

    assign sb_if.issue_ready_o = issue_ready;
    assign sb_if.irs1_busy_o   = int_busy[0];
    assign sb_if.irs2_busy_o   = int_busy[1];
    assign sb_if.frs1_busy_o   = fp_busy[0];
    assign sb_if.frs2_busy_o   = fp_busy[1];
    assign sb_if.frs3_busy_o   = fp_busy[2];
    assign sb_if.stall_o       = (|int_busy) | (|fp_busy);
    assign sb_if.empty_o       = int_empty & fp_empty;
    assign sb_if.underflow_o   = underflow_reg;

    // A dispatched instruction may write at most one register file.
    a_one_bank_write: assert property (@(posedge clk_i) disable iff (reset_i)
        !(sb_if.issue_v_i && sb_if.issue_irf_w_v_i && sb_if.issue_frf_w_v_i))
        else $error("scoreboard: issue writes both integer and FP register files");

endmodule

// File: tb/tb_bp_be_reg_scoreboard.sv
// Directed scoreboard-style bench for bp_be_reg_scoreboard.
module tb_bp_be_reg_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bp_be_reg_scoreboard_if #(.reg_addr_width_p(5)) sb_if ();

    bp_be_reg_scoreboard #(
        .max_pending_p   (3),
        .wb_bypass_p     (1'b1),
        .reg_addr_width_p(5)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .sb_if  (sb_if)
    );

    // Observed vector: {ready, irs1, irs2, frs1, frs2, frs3, stall, empty, underflow}
    typedef struct {
        string      nm;
        logic [8:0] v;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic       chk_v = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [8:0] act;

    assign act = {sb_if.issue_ready_o, sb_if.irs1_busy_o, sb_if.irs2_busy_o,
                  sb_if.frs1_busy_o, sb_if.frs2_busy_o, sb_if.frs3_busy_o,
                  sb_if.stall_o, sb_if.empty_o, sb_if.underflow_o};

    // Monitor: pops one expectation each time a checked cycle is presented.
    always @(negedge clk) begin
        if (chk_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expectation actual=%b required=queued entry", act);
            end else begin
                mon_e = exp_q.pop_front();
                if (act !== mon_e.v) begin
                    errors++;
                    $display("FAIL %s actual=%b required=%b", mon_e.nm, act, mon_e.v);
                end else begin
                    $display("check %s ok value=%b", mon_e.nm, act);
                end
            end
        end
    end

    task automatic idle();
        sb_if.clr_v_i         = 1'b0;
        sb_if.issue_v_i       = 1'b0;
        sb_if.issue_irf_w_v_i = 1'b0;
        sb_if.issue_frf_w_v_i = 1'b0;
        sb_if.issue_rd_addr_i = '0;
        sb_if.iwb_v_i         = 1'b0;
        sb_if.iwb_addr_i      = '0;
        sb_if.fwb_v_i         = 1'b0;
        sb_if.fwb_addr_i      = '0;
        sb_if.irs1_v_i        = 1'b0;
        sb_if.irs2_v_i        = 1'b0;
        sb_if.frs1_v_i        = 1'b0;
        sb_if.frs2_v_i        = 1'b0;
        sb_if.frs3_v_i        = 1'b0;
        sb_if.rs1_addr_i      = '0;
        sb_if.rs2_addr_i      = '0;
        sb_if.rs3_addr_i      = '0;
    endtask

    task automatic issue(input logic irf, input logic frf, input logic [4:0] rd);
        sb_if.issue_v_i       = 1'b1;
        sb_if.issue_irf_w_v_i = irf;
        sb_if.issue_frf_w_v_i = frf;
        sb_if.issue_rd_addr_i = rd;
    endtask

    task automatic iwb(input logic [4:0] a);
        sb_if.iwb_v_i    = 1'b1;
        sb_if.iwb_addr_i = a;
    endtask

    task automatic fwb(input logic [4:0] a);
        sb_if.fwb_v_i    = 1'b1;
        sb_if.fwb_addr_i = a;
    endtask

    // v = {irs1, irs2, frs1, frs2, frs3}
    task automatic qry(input logic [4:0] v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3);
        sb_if.irs1_v_i   = v[4];
        sb_if.irs2_v_i   = v[3];
        sb_if.frs1_v_i   = v[2];
        sb_if.frs2_v_i   = v[1];
        sb_if.frs3_v_i   = v[0];
        sb_if.rs1_addr_i = a1;
        sb_if.rs2_addr_i = a2;
        sb_if.rs3_addr_i = a3;
    endtask

    // Hold the current inputs for one cycle; optionally queue the expected outputs.
    task automatic step(input string nm, input logic chk, input logic [8:0] exp_v);
        exp_t e;
        if (chk) begin
            e.nm = nm;
            e.v  = exp_v;
            exp_q.push_back(e);
            chk_v = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_v = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step("reset_state", 1, 9'b1_00000_0_1_0);

        // Single integer writer, bypassed writeback
        issue(1, 0, 5);                          step("issue_x5", 1, 9'b1_00000_0_1_0);
        qry(5'b10000, 5, 0, 0);                  step("x5_busy", 1, 9'b1_10000_1_0_0);
        qry(5'b10000, 5, 0, 0);                  step("x5_hold", 1, 9'b1_10000_1_0_0);
        iwb(5); qry(5'b10000, 5, 0, 0);          step("x5_wb_bypass", 1, 9'b1_00000_0_0_0);
        qry(5'b10000, 5, 0, 0);                  step("x5_empty", 1, 9'b1_00000_0_1_0);

        // Saturation on x7
        issue(1, 0, 7);                          step("", 0, '0);
        issue(1, 0, 7);                          step("", 0, '0);
        issue(1, 0, 7);                          step("x7_third", 1, 9'b1_00000_0_0_0);
        sb_if.issue_irf_w_v_i = 1'b1; sb_if.issue_rd_addr_i = 7;
        qry(5'b10000, 7, 0, 0);                  step("x7_sat", 1, 9'b0_10000_1_0_0);
        issue(1, 0, 7); qry(5'b10000, 7, 0, 0);  step("x7_blocked", 1, 9'b0_10000_1_0_0);
        sb_if.issue_irf_w_v_i = 1'b1; sb_if.issue_rd_addr_i = 8;
        qry(5'b01000, 0, 7, 0);                  step("x8_ready", 1, 9'b1_01000_1_0_0);
        sb_if.issue_irf_w_v_i = 1'b1; sb_if.issue_rd_addr_i = 7;
        iwb(7); qry(5'b10000, 7, 0, 0);          step("x7_wb1", 1, 9'b0_10000_1_0_0);
        sb_if.issue_irf_w_v_i = 1'b1; sb_if.issue_rd_addr_i = 7;
        iwb(7); qry(5'b10000, 7, 0, 0);          step("x7_wb2", 1, 9'b1_10000_1_0_0);
        sb_if.issue_irf_w_v_i = 1'b1; sb_if.issue_rd_addr_i = 7;
        iwb(7); qry(5'b10000, 7, 0, 0);          step("x7_wb3", 1, 9'b1_00000_0_0_0);
        qry(5'b10000, 7, 0, 0);                  step("x7_empty", 1, 9'b1_00000_0_1_0);

        // Same-cycle issue and writeback on x9
        issue(1, 0, 9);                          step("", 0, '0);
        issue(1, 0, 9); iwb(9); qry(5'b01000, 0, 9, 0);
                                                 step("x9_issue_wb", 1, 9'b1_00000_0_0_0);
        qry(5'b01000, 0, 9, 0);                  step("x9_still", 1, 9'b1_01000_1_0_0);
        iwb(9);                                  step("", 0, '0);
                                                 step("x9_empty", 1, 9'b1_00000_0_1_0);

        // x0 untracked, f0 tracked
        issue(1, 0, 0); qry(5'b10000, 0, 0, 0);  step("x0_issue", 1, 9'b1_00000_0_1_0);
        iwb(0); qry(5'b10000, 0, 0, 0);          step("x0_query", 1, 9'b1_00000_0_1_0);
        issue(0, 1, 0);                          step("f0_issue", 1, 9'b1_00000_0_1_0);
        qry(5'b10101, 0, 0, 0);                  step("f0_busy", 1, 9'b1_00101_1_0_0);
        fwb(0);                                  step("", 0, '0);
                                                 step("f0_empty", 1, 9'b1_00000_0_1_0);

        // Flush with a same-cycle issue
        issue(1, 0, 3);                          step("", 0, '0);
        issue(1, 0, 4);                          step("", 0, '0);
        issue(0, 1, 2);                          step("", 0, '0);
        qry(5'b11001, 3, 4, 2);                  step("pend_3_4_f2", 1, 9'b1_11001_1_0_0);
        sb_if.clr_v_i = 1'b1; issue(1, 0, 6); qry(5'b11001, 3, 4, 2);
                                                 step("clr_cycle", 1, 9'b1_11001_1_0_0);
        qry(5'b11001, 3, 4, 2);                  step("after_clr", 1, 9'b1_00000_0_1_0);
        qry(5'b10000, 6, 0, 0);                  step("x6_untracked", 1, 9'b1_00000_0_1_0);

        // Underflow and asynchronous reset
        issue(1, 0, 12);                         step("", 0, '0);
        fwb(10); qry(5'b00100, 10, 0, 0);        step("f10_underflow", 1, 9'b1_00000_0_0_0);
        qry(5'b10000, 12, 0, 0);                 step("uf_sticky", 1, 9'b1_10000_1_0_1);
        qry(5'b10000, 12, 0, 0);                 step("uf_sticky2", 1, 9'b1_10000_1_0_1);
        rst = 1'b1; qry(5'b10000, 12, 0, 0);     step("async_reset", 1, 9'b1_00000_0_1_0);
        rst = 1'b0;
        iwb(11);                                 step("post_reset", 1, 9'b1_00000_0_1_0);
        sb_if.clr_v_i = 1'b1;                    step("uf_clr_cycle", 1, 9'b1_00000_0_1_1);
                                                 step("uf_cleared", 1, 9'b1_00000_0_1_0);

        // FP saturation does not block an integer write to the same index
        issue(0, 1, 20);                         step("", 0, '0);
        issue(0, 1, 20);                         step("", 0, '0);
        issue(0, 1, 20);                         step("", 0, '0);
        sb_if.issue_frf_w_v_i = 1'b1; sb_if.issue_rd_addr_i = 20;
                                                 step("f20_sat", 1, 9'b0_00000_0_0_0);
        sb_if.issue_irf_w_v_i = 1'b1; sb_if.issue_rd_addr_i = 20;
                                                 step("x20_ready", 1, 9'b1_00000_0_0_0);
        sb_if.clr_v_i = 1'b1;                    step("", 0, '0);
                                                 step("final_empty", 1, 9'b1_00000_0_1_0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_be_reg_scoreboard.md
Name: bp_be_reg_scoreboard

Overview:
Register-hazard scoreboard sitting directly downstream of the BE issue queue, in the checker next to the dispatch decision.
- Tracks outstanding writes to integer and FP architectural registers.
- Compares the source-read flags of the issued instruction (irs1/irs2/frs1/frs2/frs3 valid plus addresses, from the registered preissue packet) against pending writes.
- Reports per-source busy and an aggregate stall.
- Counts, rather than single bits, allow multiple in-flight writers to the same register (e.g. a long-latency divide followed by a load to the same rd).

Parameters:
- max_pending_p, 3, max outstanding writes per register; counter width = $clog2(max_pending_p+1).
- wb_bypass_p, 1, when 1 a same-cycle writeback that drops a count to 0 clears busy combinationally.
- reg_addr_width_p, 5, architectural register address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  async active-high reset.
- clr_v_i  in  1  flush: zero all counters.
- issue_v_i  in  1  instruction dispatched this cycle (qualified by issue_ready_o).
- issue_irf_w_v_i  in  1  dispatched instr writes the integer RF.
- issue_frf_w_v_i  in  1  dispatched instr writes the FP RF.
- issue_rd_addr_i  in  reg_addr_width_p  destination.
- issue_ready_o  out  1  low when the destination counter is saturated.
- iwb_v_i  in  1  integer writeback.
- iwb_addr_i  in  reg_addr_width_p  integer writeback address.
- fwb_v_i  in  1  FP writeback.
- fwb_addr_i  in  reg_addr_width_p  FP writeback address.
- irs1_v_i, irs2_v_i, frs1_v_i, frs2_v_i, frs3_v_i  in  1 each  source read flags.
- rs1_addr_i, rs2_addr_i, rs3_addr_i  in  reg_addr_width_p each  source addresses.
- irs1_busy_o, irs2_busy_o, frs1_busy_o, frs2_busy_o, frs3_busy_o  out  1 each  source hazard.
- stall_o  out  1  OR of all busy outputs.
- empty_o  out  1  no pending writes in either bank.
- underflow_o  out  1  sticky protocol error: writeback to a register with count 0.

Behaviour:
- Reset:
  - All counters are 0; underflow_o=0.
  - Outputs are combinational from state, so after reset: busy=0, stall_o=0, empty_o=1, issue_ready_o=1.
- Reset is async assert; deassertion is synchronous to clk_i by the upstream reset synchronizer.
- Integer register x0:
  - Never tracked. An issue or writeback to int addr 0 does not change state.
  - irs*_busy_o for addr 0 is always 0.
  - FP f0 is tracked normally.
- Per-register next-count, per bank:
  - inc = issue_v_i & issue_ready_o & bank_w_v & (addr==rd).
  - dec = bank wb_v & (addr==wb_addr).
  - inc&dec: count unchanged. inc only: +1. dec only: -1, saturating at 0, and sets underflow_o.
- issue_ready_o = ~(w_v & count[rd]==max_pending_p) for the selected bank. It is not affected by a same-cycle wb to rd; this is conservative and avoids a wb->ready timing path.
- Busy:
  - src_busy = src_v & (count[src]!=0).
  - If wb_bypass_p=1, busy is also suppressed when count[src]==1 & same-bank wb to src this cycle.
  - A same-cycle issue never makes its own sources busy, i.e. no self-hazard via rd.
- issue_irf_w_v_i and issue_frf_w_v_i both high is illegal; the integer bank takes the increment. Simulation assertion required.
- clr_v_i:
  - Next cycle all counts are 0 and underflow_o clears.
  - Same-cycle issue and writeback are ignored.
  - Busy outputs in the clr cycle still reflect the current state.
- Latency: an issue at cycle N makes busy visible at N+1. A writeback at N clears busy at N (bypass) or at N+1 (no bypass).
- empty_o = all counters zero, registered-state based.

Decomposition:
- bp_be_pkg:
  - Add localparam for counter width derivation.
  - Add a bp_be_scoreboard_query_s struct: v flags plus addresses, reusable from the preissue packet fields.
- Sub-module bp_be_scoreboard_bank:
  - Parameters: els=32, zero_reg_p (1 for int, 0 for FP).
  - Holds counters, inc/dec logic, three read ports, saturation flag, underflow pulse, all-zero flag.
  - Instantiated twice: int bank with 2 query ports used, FP bank with 3.

Test Plan:
- Reset then issue int rd=5 at cycle 1, query irs1=5 at cycle 2 -> irs1_busy_o=1, stall_o=1; iwb addr=5 at cycle 4 -> busy=0 same cycle (bypass=1), empty_o=1 at cycle 5.
- Issue rd=7 three times with no wb -> count 3, issue_ready_o=0 for rd=7 but 1 for rd=8; one iwb 7 -> ready returns next cycle; two more wbs -> still busy until the third.
- Same-cycle issue rd=9 and iwb 9 with count=1 -> count stays 1, irs2 query on 9 busy=1 next cycle.
- Issue to x0 and query irs1=0 -> busy=0, empty_o stays 1; FP issue fd=0 then frs3=0 -> frs3_busy_o=1.
- Pending on x3, x4, f2, then clr_v_i with same-cycle issue rd=6 -> next cycle all busy=0, empty_o=1, x6 not tracked.
- fwb to f10 with count 0 -> underflow_o=1 sticky, count stays 0; async reset asserted mid-cycle -> underflow_o=0 and empty_o=1 immediately, without waiting for a clock edge.
